// File: rtl/lab3_cache_mem_arbiter_if.sv
// Message types and the bundled val/rdy channels between the two cache
// ports, the shared memory port and the arbiter.
package lab3_mem_pkg;

  typedef struct packed {
    logic [2:0]  msgType;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msgType;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

interface lab3_cache_mem_arbiter_if;
  import lab3_mem_pkg::*;

  logic          req0_val, req0_rdy, req1_val, req1_rdy;
  mem_req_4B_t   req0_msg, req1_msg;
  logic          resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  mem_resp_4B_t  resp0_msg, resp1_msg;
  logic          mem_req_val, mem_req_rdy;
  mem_req_4B_t   mem_req_msg;
  logic          mem_resp_val, mem_resp_rdy;
  mem_resp_4B_t  mem_resp_msg;

  // The environment side: caches and memory.
  modport master (
    output req0_val, req0_msg, req1_val, req1_msg,
    input  req0_rdy, req1_rdy,
    input  resp0_val, resp0_msg, resp1_val, resp1_msg,
    output resp0_rdy, resp1_rdy,
    input  mem_req_val, mem_req_msg,
    output mem_req_rdy,
    output mem_resp_val, mem_resp_msg,
    input  mem_resp_rdy
  );

  modport slave (
    input  req0_val, req0_msg, req1_val, req1_msg,
    output req0_rdy, req1_rdy,
    output resp0_val, resp0_msg, resp1_val, resp1_msg,
    input  resp0_rdy, resp1_rdy,
    output mem_req_val, mem_req_msg,
    input  mem_req_rdy,
    input  mem_resp_val, mem_resp_msg,
    output mem_resp_rdy
  );

endinterface

// File: rtl/lab3_cache_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between icache and
// dcache; a FIFO of port IDs steers each response back to its requester.
module lab3_cache_mem_arbiter #(
  parameter int p_depth = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  lab3_cache_mem_arbiter_if.slave    bus,
  output logic [$clog2(p_depth):0]   outstanding
);

  localparam int PtrW = $clog2(p_depth);
  localparam int CntW = PtrW + 1;

  logic            idFifo_q [p_depth];
  logic [PtrW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            prio_q, prio_d;

  logic fifoFull, fifoEmpty, grant, head, reqOpen, respOpen, push, pop;

  always_comb begin
    fifoFull  = (count_q == CntW'(p_depth));
    fifoEmpty = (count_q == '0);
  end

  // Request side only looks at request inputs and registered FIFO state,
  // so nothing from the response channel leaks into it.
  always_comb begin
    if (bus.req0_val && bus.req1_val) grant = prio_q;
    else                              grant = bus.req1_val;
    reqOpen          = reset & (bus.req0_val | bus.req1_val) & ~fifoFull;
    bus.mem_req_val  = reqOpen;
    bus.req0_rdy     = reqOpen & ~grant & bus.mem_req_rdy;
    bus.req1_rdy     = reqOpen &  grant & bus.mem_req_rdy;
    bus.mem_req_msg  = grant ? bus.req1_msg : bus.req0_msg;
    push             = reqOpen & bus.mem_req_rdy;
  end

  // An empty FIFO means the response is unexpected and is neither accepted
  // nor forwarded.
  always_comb begin
    head             = idFifo_q[rdPtr_q];
    respOpen         = reset & ~fifoEmpty;
    bus.resp0_val    = respOpen & bus.mem_resp_val & ~head;
    bus.resp1_val    = respOpen & bus.mem_resp_val &  head;
    bus.resp0_msg    = bus.mem_resp_msg;
    bus.resp1_msg    = bus.mem_resp_msg;
    bus.mem_resp_rdy = respOpen & (head ? bus.resp1_rdy : bus.resp0_rdy);
    pop              = bus.mem_resp_val & bus.mem_resp_rdy;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    count_d = count_q + CntW'(push) - CntW'(pop);
    wrPtr_d = wrPtr_q + PtrW'(push);
    rdPtr_d = rdPtr_q + PtrW'(pop);
    prio_d  = push ? ~grant : prio_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      prio_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      prio_q  <= prio_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) idFifo_q[wrPtr_q] <= grant;
  end

  always_comb outstanding = count_q;

endmodule

// File: tb/tb_lab3_cache_mem_arbiter.sv
// Bench for lab3_cache_mem_arbiter: fixed vector table, directed corner
// sequences and random traffic checked against a queue-based model.
module tb_lab3_cache_mem_arbiter;
  import lab3_mem_pkg::*;

  localparam int Depth = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [$clog2(Depth):0] outstanding;

  lab3_cache_mem_arbiter_if bus();

  lab3_cache_mem_arbiter #(.p_depth(Depth)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v0, v1, mrr, mrv, r0r, r1r;
    bit eReqVal, eRdy0, eRdy1, eResp0, eResp1, eRespRdy;
    int eOut;
    bit eGrant;
  } vec_t;

  int passCount = 0;
  int checkCount = 0;

  bit modelQ[$];
  bit modelPrio;
  bit grantLog[$];
  bit respLog[$];

  mem_req_4B_t  reqMsg0, reqMsg1;
  mem_resp_4B_t respMsg;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  function automatic mem_req_4B_t randReq();
    mem_req_4B_t m;
    m.msgType = 3'($urandom);
    m.opaque  = 8'($urandom);
    m.addr    = $urandom;
    m.len     = 2'($urandom);
    m.data    = $urandom;
    return m;
  endfunction

  function automatic mem_resp_4B_t randResp();
    mem_resp_4B_t m;
    m.msgType = 3'($urandom);
    m.opaque  = 8'($urandom);
    m.test    = 2'($urandom);
    m.len     = 2'($urandom);
    m.data    = $urandom;
    return m;
  endfunction

  task automatic driveInputs(input bit v0, v1, mrr, mrv, r0r, r1r);
    bus.req0_val     = v0;
    bus.req1_val     = v1;
    bus.mem_req_rdy  = mrr;
    bus.mem_resp_val = mrv;
    bus.resp0_rdy    = r0r;
    bus.resp1_rdy    = r1r;
    bus.req0_msg     = reqMsg0;
    bus.req1_msg     = reqMsg1;
    bus.mem_resp_msg = respMsg;
  endtask

  // One cycle against the model: the model is an in-order queue of requester
  // IDs plus a favoured-port bit, advanced only by the transfers it predicts.
  task automatic applyStimulus(input bit v0, v1, mrr, mrv, r0r, r1r);
    bit full, grantP, expReqVal, expR0, expR1, expRespRdy, reqXfer, respXfer;
    driveInputs(v0, v1, mrr, mrv, r0r, r1r);
    #1;
    full      = (modelQ.size() == Depth);
    grantP    = (v0 && v1) ? modelPrio : v1;
    expReqVal = (v0 || v1) && !full;
    checkOutput("mem_req_val", 128'(bus.mem_req_val), 128'(expReqVal));
    checkOutput("req0_rdy", 128'(bus.req0_rdy), 128'(expReqVal && mrr && !grantP));
    checkOutput("req1_rdy", 128'(bus.req1_rdy), 128'(expReqVal && mrr && grantP));
    if (expReqVal)
      checkOutput("mem_req_msg", 128'(bus.mem_req_msg), 128'(grantP ? reqMsg1 : reqMsg0));
    expR0      = (modelQ.size() > 0) && mrv && (modelQ[0] == 1'b0);
    expR1      = (modelQ.size() > 0) && mrv && (modelQ[0] == 1'b1);
    expRespRdy = (modelQ.size() > 0) && (modelQ[0] ? r1r : r0r);
    checkOutput("resp0_val", 128'(bus.resp0_val), 128'(expR0));
    checkOutput("resp1_val", 128'(bus.resp1_val), 128'(expR1));
    checkOutput("mem_resp_rdy", 128'(bus.mem_resp_rdy), 128'(expRespRdy));
    checkOutput("outstanding", 128'(outstanding), 128'(modelQ.size()));
    if (expR0) checkOutput("resp0_msg", 128'(bus.resp0_msg), 128'(respMsg));
    if (expR1) checkOutput("resp1_msg", 128'(bus.resp1_msg), 128'(respMsg));
    reqXfer  = expReqVal && mrr;
    respXfer = mrv && expRespRdy;
    @(posedge clk);
    if (respXfer) respLog.push_back(modelQ.pop_front());
    if (reqXfer) begin
      modelQ.push_back(grantP);
      grantLog.push_back(grantP);
      modelPrio = !grantP;
    end
    #1;
  endtask

  // Reset is asserted with every input active so the output gating is seen.
  task automatic doReset();
    driveInputs(1, 1, 1, 1, 1, 1);
    reset = 1'b0;
    #1;
    checkOutput("rst_outstanding", 128'(outstanding), 128'(0));
    checkOutput("rst_mem_req_val", 128'(bus.mem_req_val), 128'(0));
    checkOutput("rst_req_rdy", 128'({bus.req0_rdy, bus.req1_rdy}), 128'(0));
    checkOutput("rst_resp_val", 128'({bus.resp0_val, bus.resp1_val}), 128'(0));
    checkOutput("rst_mem_resp_rdy", 128'(bus.mem_resp_rdy), 128'(0));
    modelQ.delete();
    modelPrio = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1,1,1,0,1,1, 1,1,0,0,0,0, 0, 0};
    vecs[1] = '{1,1,1,0,1,1, 1,0,1,0,0,1, 1, 1};
    vecs[2] = '{0,1,0,1,1,1, 1,0,0,1,0,1, 2, 1};
    vecs[3] = '{1,0,1,1,1,0, 1,1,0,0,1,0, 1, 0};
    vecs[4] = '{0,0,1,1,0,1, 0,0,0,0,1,1, 2, 0};
    vecs[5] = '{0,0,1,1,1,0, 0,0,0,1,0,1, 1, 0};
    vecs[6] = '{0,0,1,1,1,1, 0,0,0,0,0,0, 0, 0};
    vecs[7] = '{1,1,1,0,1,1, 1,0,1,0,0,0, 0, 1};

    reqMsg0 = randReq();
    reqMsg1 = randReq();
    respMsg = randResp();
    doReset();

    for (int i = 0; i < 8; i++) begin
      driveInputs(vecs[i].v0, vecs[i].v1, vecs[i].mrr, vecs[i].mrv, vecs[i].r0r, vecs[i].r1r);
      #1;
      checkOutput($sformatf("vec%0d_mem_req_val", i), 128'(bus.mem_req_val), 128'(vecs[i].eReqVal));
      checkOutput($sformatf("vec%0d_req0_rdy", i), 128'(bus.req0_rdy), 128'(vecs[i].eRdy0));
      checkOutput($sformatf("vec%0d_req1_rdy", i), 128'(bus.req1_rdy), 128'(vecs[i].eRdy1));
      checkOutput($sformatf("vec%0d_resp0_val", i), 128'(bus.resp0_val), 128'(vecs[i].eResp0));
      checkOutput($sformatf("vec%0d_resp1_val", i), 128'(bus.resp1_val), 128'(vecs[i].eResp1));
      checkOutput($sformatf("vec%0d_mem_resp_rdy", i), 128'(bus.mem_resp_rdy), 128'(vecs[i].eRespRdy));
      checkOutput($sformatf("vec%0d_outstanding", i), 128'(outstanding), 128'(vecs[i].eOut));
      if (vecs[i].eReqVal)
        checkOutput($sformatf("vec%0d_mem_req_msg", i), 128'(bus.mem_req_msg),
                    128'(vecs[i].eGrant ? reqMsg1 : reqMsg0));
      @(posedge clk);
      #1;
    end

    // Single port: three reads then three in-order responses.
    doReset();
    for (int i = 0; i < 3; i++) begin
      reqMsg0.opaque = 8'(i);
      applyStimulus(1, 0, 1, 0, 1, 1);
    end
    checkOutput("single_peak_outstanding", 128'(outstanding), 128'(3));
    for (int i = 0; i < 3; i++) begin
      respMsg.opaque = 8'(i);
      applyStimulus(0, 0, 1, 1, 1, 1);
    end

    // Contention: both ports always valid, memory always ready.
    doReset();
    grantLog.delete();
    respLog.delete();
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("contention_grant%0d", i), 128'(grantLog[i]), 128'(i % 2));
      checkOutput($sformatf("contention_resp%0d", i), 128'(respLog[i]), 128'(i % 2));
    end

    // Full: six offers with no responses, then one response frees a slot.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 1, 0, 1, 1);
    checkOutput("full_outstanding", 128'(outstanding), 128'(4));
    checkOutput("full_mem_req_val", 128'(bus.mem_req_val), 128'(0));
    applyStimulus(1, 0, 1, 1, 1, 1);
    driveInputs(1, 0, 1, 0, 1, 1);
    #1;
    checkOutput("full_reaccept_rdy", 128'(bus.req0_rdy), 128'(1));
    applyStimulus(1, 0, 1, 0, 1, 1);
    checkOutput("full_refilled", 128'(outstanding), 128'(4));

    // Backpressure on port 1 while it owns the head.
    doReset();
    applyStimulus(0, 1, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 1, 1, 0);
      checkOutput($sformatf("bp_hold%0d", i), 128'(outstanding), 128'(1));
    end
    applyStimulus(0, 0, 1, 1, 1, 1);
    checkOutput("bp_popped", 128'(outstanding), 128'(0));

    // Simultaneous push and pop at count 2, long enough to wrap the pointers.
    doReset();
    applyStimulus(1, 1, 1, 0, 1, 1);
    applyStimulus(1, 1, 1, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 1, 1, 1, 1);
      checkOutput($sformatf("pp_count%0d", i), 128'(outstanding), 128'(2));
    end

    // Reset with three requests in flight, then a stale response.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 1, 1);
    checkOutput("midrst_before", 128'(outstanding), 128'(3));
    doReset();
    applyStimulus(0, 0, 1, 1, 1, 1);
    applyStimulus(0, 0, 1, 1, 1, 1);

    // Random traffic.
    doReset();
    for (int i = 0; i < 400; i++) begin
      reqMsg0 = randReq();
      reqMsg1 = randReq();
      respMsg = randResp();
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/lab3_cache_mem_arbiter.md
LAB3_CACHE_MEM_ARBITER -- requirements
Module: lab3_cache_mem_arbiter

Interface
REQ-001 The block SHALL have parameter p_depth, default 4, setting the outstanding-request tracking depth; legal values are 2, 4 or 8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0_val / req0_rdy / req0_msg  in/out/in  1/1/mem_req_4B_t  port 0 (icache) request from the cache's memory-side port.
REQ-005 resp0_val / resp0_rdy / resp0_msg  out/in/out  1/1/mem_resp_4B_t  port 0 response.
REQ-006 req1_val / req1_rdy / req1_msg  in/out/in  1/1/mem_req_4B_t  port 1 (dcache) request.
REQ-007 resp1_val / resp1_rdy / resp1_msg  out/in/out  1/1/mem_resp_4B_t  port 1 response.
REQ-008 mem_req_val / mem_req_rdy / mem_req_msg  out/in/out  1/1/mem_req_4B_t  shared memory request.
REQ-009 mem_resp_val / mem_resp_rdy / mem_resp_msg  in/out/in  1/1/mem_resp_4B_t  shared memory response; memory returns responses in request order.
REQ-010 outstanding  output  $clog2(p_depth)+1  count of accepted requests not yet answered.

Function
REQ-011 A val/rdy transfer SHALL occur only in a cycle where both val and rdy are 1 at the rising edge.
REQ-012 The tracking FIFO SHALL hold p_depth one-bit port IDs, with read pointer, write pointer and count registers.
REQ-013 The request path SHALL be combinational: mem_req_msg equals the granted port's msg, unmodified, including opaque.
REQ-014 Grant SHALL be round-robin: the prio register names the favoured port; if only one port is valid, that port is granted.
REQ-015 mem_req_val SHALL be 1 iff at least one reqN_val is 1 and the FIFO is not full.
REQ-016 reqN_rdy SHALL be 1 iff port N is granted, the FIFO is not full, and mem_req_rdy is 1; the non-granted port's rdy SHALL be 0.
REQ-017 On a memory request transfer, the granted port ID SHALL be pushed and prio SHALL become the other port.
REQ-018 prio SHALL be unchanged in cycles with no request transfer.
REQ-019 When the FIFO is full, no push SHALL occur, even if a pop happens in the same cycle.
REQ-020 The response path SHALL be combinational: mem_resp_msg goes to the port named by the FIFO head.
REQ-021 respN_val SHALL equal mem_resp_val AND (head == N) AND (FIFO not empty); the other port's resp_val SHALL be 0.
REQ-022 mem_resp_rdy SHALL equal the head port's respN_rdy when the FIFO is not empty, and 0 when it is empty.
REQ-023 The FIFO head SHALL be popped on a response transfer to the destination port.
REQ-024 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-025 Pointers SHALL wrap modulo p_depth.
REQ-026 outstanding SHALL equal the FIFO count.
REQ-027 A memory response arriving while the FIFO is empty is a protocol error: it SHALL NOT be accepted and SHALL NOT be forwarded.
REQ-028 No output SHALL depend combinationally on a response input feeding the request path, or the reverse; no paths cross between the request and response sides.

Reset
REQ-029 While reset == 0, the FIFO SHALL be empty, both pointers 0, prio = 0 and outstanding = 0, taking effect asynchronously.
REQ-030 While reset == 0, all val and rdy outputs SHALL be 0.
REQ-031 An assertion of reset mid-operation SHALL discard all tracked requests, with no response forwarded afterward for them.
REQ-032 Release of reset SHALL be synchronous to clk, and normal operation SHALL start on the first rising edge after release.

Verification
REQ-033 Scenario: single port. req0 issues 3 reads (opaque 0,1,2) while memory is always ready, and memory returns them in order. Required: every response appears on resp0 with matching opaque, resp1_val stays 0, and outstanding peaks at 3.
REQ-034 Scenario: contention. Both ports are valid every cycle after reset and mem_req_rdy = 1. Required: grants alternate 0,1,0,1, and responses return to ports 0,1,0,1.
REQ-035 Scenario: full. p_depth = 4, memory withholds responses, and 6 requests are offered. Required: exactly 4 are accepted, then mem_req_val = 0 and outstanding = 4; after one response is consumed, one further request is accepted the following cycle.
REQ-036 Scenario: backpressure. Head is port 1, mem_resp_val = 1 and resp1_rdy = 0 for 3 cycles. Required: mem_resp_rdy = 0 and the FIFO is unchanged for those cycles; the transfer and pop occur in the cycle resp1_rdy rises.
REQ-037 Scenario: simultaneous push and pop at count 2. Required: count stays 2 and the pointers wrap correctly across 10 such cycles.
REQ-038 Scenario: reset mid-operation. reset is asserted with 3 requests outstanding. Required: outstanding = 0 immediately, all rdy/val outputs are 0, and a stale mem_resp_val after release is not accepted.
